led_pattern_driver: RTL and testbench
=====================================

// Module: led_pattern_driver
// PURPOSE
//   Output-side counterpart to the board's switch-input logic. Accepts an LED
//   display command (pattern, brightness, duration) over a valid/ready handshake.
//   Drives the LEDs with PWM dimming for the commanded time, then reports
//   completion. Sits between control logic and the board LED pins.
// PARAMETERS
//   NUM_LEDS       4      number of LED outputs
//   PWM_BITS       4      brightness resolution; PWM period = 2**PWM_BITS clocks
//   DUR_BITS       8      width of duration field, in ticks
//   CLKS_PER_TICK  25000  clocks per duration tick (1 ms at 25 MHz)
// PORTS
//   i_Clk       in   1         system clock, all logic on rising edge
//   i_Rst_L     in   1         asynchronous reset, active low
//   i_Valid     in   1         command valid
//   o_Ready     out  1         block can accept a command
//   i_Pattern   in   NUM_LEDS  1 = LED participates
//   i_Bright    in   PWM_BITS  duty level; 0 = off, all-ones = fully on
//   i_Duration  in   DUR_BITS  display time in ticks
//   i_Abort     in   1         cancel the active command
//   o_LED       out  NUM_LEDS  LED drive, registered, 1 = lit
//   o_Done      out  1         one-cycle pulse when a command completes normally
// BEHAVIOUR
//   Reset (async, i_Rst_L=0):
//     state=IDLE, o_LED=0, o_Done=0, o_Ready=1 once reset releases.
//     All counters are cleared. Reset mid-SHOW drops the command with no o_Done.
//   States:
//     IDLE: o_Ready=1, o_LED=0.
//       On i_Valid at a clock edge, capture pattern, bright and duration.
//       If duration!=0, go to SHOW. If duration==0, stay IDLE and pulse o_Done
//       next cycle.
//     SHOW: o_Ready=0; i_Valid ignored.
//   Ready is decoded from the state register only (no combinational input->output path).
//   PWM:
//     pwm_cnt is a free-running PWM_BITS counter, +1 every clock, wraps.
//     lit = (bright==all-ones) | (pwm_cnt < bright).
//     o_LED <= pattern & {NUM_LEDS{lit}} while in SHOW; else 0.
//     One cycle of register latency from state/counter to pin.
//   Timing:
//     The tick prescaler clears on accept and counts 0..CLKS_PER_TICK-1.
//     The duration counter decrements at each prescaler wrap.
//     SHOW lasts exactly duration*CLKS_PER_TICK clocks. On the last one,
//     go to IDLE, o_Done=1 for one cycle and o_LED=0 on the same edge.
//     A new command is accepted on the cycle after o_Done, at the earliest.
//   Abort:
//     i_Abort in SHOW -> IDLE at next edge, o_LED=0, no o_Done.
//     i_Abort in IDLE is ignored (a simultaneous i_Valid is still accepted).
//     Abort on the final SHOW cycle: abort wins, no o_Done.
//   Widths:
//     Counters are unsigned and never wrap in SHOW.
//     duration max = 2**DUR_BITS-1 ticks.
// TESTING  (bench: CLKS_PER_TICK=4, PWM_BITS=4, DUR_BITS=8)
//   1. Reset held, then released -> o_LED=0, o_Done=0, o_Ready=1.
//      Assert i_Rst_L low mid-SHOW -> outputs clear immediately (asynchronous).
//   2. Pattern=4'b1010, bright=15, dur=3 -> o_LED=1010 for 12 clocks.
//      o_Ready low for exactly 12 clocks, then one o_Done pulse.
//   3. Pattern=4'b1111, bright=4, dur=8 -> each LED high 4 of every 16 clocks
//      (25%) throughout SHOW. bright=0 -> LEDs never lit, o_Done still fires.
//   4. Dur=0 -> no SHOW, o_LED stays 0, o_Done pulses the next cycle.
//   5. Dur=10, i_Abort pulsed at clock 7 of SHOW -> o_LED=0 and o_Ready=1
//      the next cycle, no o_Done. Abort on the final cycle also gives no o_Done.
//   6. i_Valid held high with new commands -> the next command is accepted
//      the cycle after o_Done. Pattern changes during SHOW have no effect.

Source files
------------

// File: rtl/led_pattern_driver.sv
//==============================================================================
// Module      : led_pattern_driver
// Description : Shows a commanded LED pattern with PWM dimming for a set number
//               of ticks, then pulses o_Done. Abortable, valid/ready accept.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_pattern_driver #(
    parameter int NUM_LEDS      = 4,
    parameter int PWM_BITS      = 4,
    parameter int DUR_BITS      = 8,
    parameter int CLKS_PER_TICK = 25000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Valid,
    output logic                o_Ready,
    input  logic [NUM_LEDS-1:0] i_Pattern,
    input  logic [PWM_BITS-1:0] i_Bright,
    input  logic [DUR_BITS-1:0] i_Duration,
    input  logic                i_Abort,
    output logic [NUM_LEDS-1:0] o_LED,
    output logic                o_Done
);

    localparam int PRE_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PRE_W-1:0]    C_PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [DUR_BITS-1:0] C_DUR_ONE  = DUR_BITS'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t              state_q;
    logic [NUM_LEDS-1:0] pattern_q;
    logic [PWM_BITS-1:0] bright_q;
    logic [DUR_BITS-1:0] dur_q;
    logic [PRE_W-1:0]    pre_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [NUM_LEDS-1:0] led_q;
    logic                done_q;

    logic                lit_new_d;
    logic                lit_cur_d;
    logic [NUM_LEDS-1:0] led_cur_d;

    // LED register is loaded from the next-state view so the pins light on the
    // first SHOW cycle and go dark on the same edge that leaves SHOW.
    always_comb begin
        lit_new_d = (i_Bright == '1) || (pwm_q < i_Bright);
        lit_cur_d = (bright_q == '1) || (pwm_q < bright_q);
        led_cur_d = pattern_q & {NUM_LEDS{lit_cur_d}};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            bright_q  <= '0;
            dur_q     <= '0;
            pre_q     <= '0;
            pwm_q     <= '0;
            led_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            pwm_q  <= pwm_q + 1'b1;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    led_q <= '0;
                    if (i_Valid) begin
                        pattern_q <= i_Pattern;
                        bright_q  <= i_Bright;
                        dur_q     <= i_Duration;
                        pre_q     <= '0;
                        if (i_Duration != '0) begin
                            state_q <= ST_SHOW;
                            led_q   <= i_Pattern & {NUM_LEDS{lit_new_d}};
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (i_Abort) begin
                        state_q <= ST_IDLE;
                        led_q   <= '0;
                    end else if (pre_q == C_PRE_LAST) begin
                        pre_q <= '0;
                        if (dur_q == C_DUR_ONE) begin
                            state_q <= ST_IDLE;
                            led_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            dur_q <= dur_q - 1'b1;
                            led_q <= led_cur_d;
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                        led_q <= led_cur_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= '0;
                end
            endcase
        end
    end

    assign o_Ready = (state_q == ST_IDLE);
    assign o_LED   = led_q;
    assign o_Done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_driver.sv
//==============================================================================
// Module      : tb_led_pattern_driver
// Description : Directed self-checking bench for led_pattern_driver (tick = 4 clocks).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_pattern_driver;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Valid = 1'b0;
    logic       o_Ready;
    logic [3:0] i_Pattern = '0;
    logic [3:0] i_Bright = '0;
    logic [7:0] i_Duration = '0;
    logic       i_Abort = 1'b0;
    logic [3:0] o_LED;
    logic       o_Done;

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_driver #(
        .NUM_LEDS(4), .PWM_BITS(4), .DUR_BITS(8), .CLKS_PER_TICK(4)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Pattern(i_Pattern), .i_Bright(i_Bright), .i_Duration(i_Duration),
        .i_Abort(i_Abort), .o_LED(o_LED), .o_Done(o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic cmd(input logic [3:0] p, input logic [3:0] b, input logic [7:0] d);
        i_Pattern  = p;
        i_Bright   = b;
        i_Duration = d;
        i_Valid    = 1'b1;
        @(negedge i_Clk);
        i_Valid = 1'b0;
    endtask

    task automatic test_reset();
        i_Rst_L = 1'b0;
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        n_checks++;
        if ({o_LED, o_Done, o_Ready} !== 6'b0000_0_1) begin
            $display("FAIL reset_release: LED=%b Done=%b Ready=%b expected 0000/0/1", o_LED, o_Done, o_Ready);
            n_fail++;
        end
        cmd(4'b1111, 4'hF, 8'd5);
        repeat (3) @(negedge i_Clk);
        n_checks++;
        if (o_LED !== 4'b1111) begin
            $display("FAIL reset_preshow: LED=%b expected 1111", o_LED);
            n_fail++;
        end
        #2 i_Rst_L = 1'b0;
        #1;
        n_checks++;
        if ({o_LED, o_Done, o_Ready} !== 6'b0000_0_1) begin
            $display("FAIL reset_async: LED=%b Done=%b Ready=%b expected 0000/0/1", o_LED, o_Done, o_Ready);
            n_fail++;
        end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        begin
            int dones = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge i_Clk);
                if (o_Done === 1'b1) dones++;
            end
            n_checks++;
            if (dones !== 0) begin
                $display("FAIL reset_no_done: done pulses=%0d expected 0", dones);
                n_fail++;
            end
        end
    endtask

    task automatic test_full_on();
        cmd(4'b1010, 4'hF, 8'd3);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if ({o_LED, o_Ready, o_Done} !== 6'b1010_0_0) begin
                $display("FAIL full_on_show[%0d]: LED=%b Ready=%b Done=%b expected 1010/0/0", i, o_LED, o_Ready, o_Done);
                n_fail++;
            end
            @(negedge i_Clk);
        end
        n_checks++;
        if ({o_LED, o_Ready, o_Done} !== 6'b0000_1_1) begin
            $display("FAIL full_on_end: LED=%b Ready=%b Done=%b expected 0000/1/1", o_LED, o_Ready, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
        n_checks++;
        if (o_Done !== 1'b0) begin
            $display("FAIL full_on_pulse_width: Done=%b expected 0", o_Done);
            n_fail++;
        end
    endtask

    task automatic test_pwm(input logic [3:0] b, input logic [7:0] d, input int exp_lit);
        int lit = 0;
        int bad = 0;
        cmd(4'b1111, b, d);
        for (int i = 0; i < 4 * int'(d); i++) begin
            if (o_LED === 4'b1111) lit++;
            else if (o_LED !== 4'b0000 || o_Ready !== 1'b0) bad++;
            @(negedge i_Clk);
        end
        n_checks++;
        if (lit !== exp_lit || bad !== 0) begin
            $display("FAIL pwm_b%0d: lit cycles=%0d bad=%0d expected lit=%0d bad=0", b, lit, bad, exp_lit);
            n_fail++;
        end
        n_checks++;
        if ({o_LED, o_Done} !== 5'b0000_1) begin
            $display("FAIL pwm_b%0d_done: LED=%b Done=%b expected 0000/1", b, o_LED, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
    endtask

    task automatic test_zero_dur();
        cmd(4'b1111, 4'hF, 8'd0);
        n_checks++;
        if ({o_LED, o_Ready, o_Done} !== 6'b0000_1_1) begin
            $display("FAIL zero_dur: LED=%b Ready=%b Done=%b expected 0000/1/1", o_LED, o_Ready, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
        n_checks++;
        if ({o_LED, o_Done} !== 5'b0000_0) begin
            $display("FAIL zero_dur_after: LED=%b Done=%b expected 0000/0", o_LED, o_Done);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        i_Abort = 1'b1;
        cmd(4'b0110, 4'hF, 8'd10);
        i_Abort = 1'b0;
        n_checks++;
        if ({o_Ready, o_LED} !== 5'b0_0110) begin
            $display("FAIL abort_idle_accept: Ready=%b LED=%b expected 0/0110", o_Ready, o_LED);
            n_fail++;
        end
        repeat (6) @(negedge i_Clk);
        i_Abort = 1'b1;
        @(negedge i_Clk);
        i_Abort = 1'b0;
        n_checks++;
        if ({o_LED, o_Ready, o_Done} !== 6'b0000_1_0) begin
            $display("FAIL abort_mid: LED=%b Ready=%b Done=%b expected 0000/1/0", o_LED, o_Ready, o_Done);
            n_fail++;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge i_Clk);
            if (o_Done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            $display("FAIL abort_mid_no_done: done pulses=%0d expected 0", dones);
            n_fail++;
        end
        cmd(4'b1001, 4'hF, 8'd1);
        repeat (3) @(negedge i_Clk);
        i_Abort = 1'b1;
        @(negedge i_Clk);
        i_Abort = 1'b0;
        n_checks++;
        if ({o_LED, o_Ready, o_Done} !== 6'b0000_1_0) begin
            $display("FAIL abort_final: LED=%b Ready=%b Done=%b expected 0000/1/0", o_LED, o_Ready, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
        n_checks++;
        if (o_Done !== 1'b0) begin
            $display("FAIL abort_final_late: Done=%b expected 0", o_Done);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        i_Pattern  = 4'b1100;
        i_Bright   = 4'hF;
        i_Duration = 8'd1;
        i_Valid    = 1'b1;
        @(negedge i_Clk);
        i_Pattern  = 4'b0011;
        i_Duration = 8'd2;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({o_LED, o_Ready} !== 5'b1100_0) begin
                $display("FAIL b2b_first[%0d]: LED=%b Ready=%b expected 1100/0", i, o_LED, o_Ready);
                n_fail++;
            end
            @(negedge i_Clk);
        end
        n_checks++;
        if ({o_LED, o_Ready, o_Done} !== 6'b0000_1_1) begin
            $display("FAIL b2b_done: LED=%b Ready=%b Done=%b expected 0000/1/1", o_LED, o_Ready, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
        i_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({o_LED, o_Ready, o_Done} !== 6'b0011_0_0) begin
                $display("FAIL b2b_second[%0d]: LED=%b Ready=%b Done=%b expected 0011/0/0", i, o_LED, o_Ready, o_Done);
                n_fail++;
            end
            @(negedge i_Clk);
        end
        n_checks++;
        if ({o_LED, o_Done} !== 5'b0000_1) begin
            $display("FAIL b2b_second_done: LED=%b Done=%b expected 0000/1", o_LED, o_Done);
            n_fail++;
        end
        @(negedge i_Clk);
    endtask

    initial begin
        @(negedge i_Clk);
        test_reset();
        test_full_on();
        test_pwm(4'd4, 8'd8, 8);
        test_pwm(4'd0, 8'd2, 0);
        test_zero_dur();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
